// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arb_pkg
// Purpose  : Shared channel count, index type and rotate helper for the
//            4-channel round-robin arbiter.
// Revision : 1.0
// ============================================================================
package arb_pkg;

    localparam int N_CH = 4;

    typedef logic [1:0] ch_idx_t;

    // Left rotate by s: result[j] = v[(j - s) mod 4].
    function automatic logic [3:0] rotate_l4(input logic [3:0] v, input ch_idx_t s);
        logic [3:0] r;
        case (s)
            2'd0:    r = v;
            2'd1:    r = {v[2:0], v[3]};
            2'd2:    r = {v[1:0], v[3:2]};
            default: r = {v[0], v[3:1]};
        endcase
        return r;
    endfunction

endpackage : arb_pkg
`default_nettype wire

// File: rtl/rr_pick_4.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick_4
// Purpose  : Combinational round-robin picker; the lowest-numbered request
//            at or after ptr (mod 4) wins.
// Revision : 1.0
// ============================================================================
module rr_pick_4
    import arb_pkg::*;
(
    input  logic [3:0] req,
    input  ch_idx_t    ptr,
    output logic       gnt_any,
    output ch_idx_t    gnt_idx,
    output logic [3:0] gnt_onehot
);

    ch_idx_t    w_neg_ptr;
    logic [3:0] w_rot_req;
    logic [3:0] w_rot_oh;
    ch_idx_t    w_rot_idx;

    // Rotating by -ptr moves request ptr to bit 0, so bit 0 is top priority.
    assign w_neg_ptr = ~ptr + 2'd1;
    assign w_rot_req = rotate_l4(req, w_neg_ptr);

    always_comb begin
        w_rot_oh  = 4'b0000;
        w_rot_idx = 2'd0;
        if (w_rot_req[0]) begin
            w_rot_oh  = 4'b0001;
            w_rot_idx = 2'd0;
        end else if (w_rot_req[1]) begin
            w_rot_oh  = 4'b0010;
            w_rot_idx = 2'd1;
        end else if (w_rot_req[2]) begin
            w_rot_oh  = 4'b0100;
            w_rot_idx = 2'd2;
        end else if (w_rot_req[3]) begin
            w_rot_oh  = 4'b1000;
            w_rot_idx = 2'd3;
        end
    end

    assign gnt_any    = |req;
    assign gnt_idx    = w_rot_idx + ptr;
    assign gnt_onehot = rotate_l4(w_rot_oh, ptr);

endmodule : rr_pick_4
`default_nettype wire

// File: rtl/rr_arb_mux_4.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb_mux_4
// Purpose  : 4-channel round-robin arbiter feeding a registered 4:1 data mux
//            with a valid/ready output stage (1 word/cycle, 1-cycle latency).
// Revision : 1.0
// ============================================================================
module rr_arb_mux_4
    import arb_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       in_valid,
    input  logic [WIDTH-1:0] in_data [0:N_CH-1],
    output logic [3:0]       in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output ch_idx_t          out_sel,
    input  logic             out_ready
);

    ch_idx_t          r_ptr;
    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    ch_idx_t          r_sel;

    logic             w_load;
    logic             w_gnt_any;
    ch_idx_t          w_gnt_idx;
    logic [3:0]       w_gnt_oh;
    logic             w_fire;
    logic [WIDTH-1:0] w_mux_data;

    rr_pick_4 u_pick (
        .req        (in_valid),
        .ptr        (r_ptr),
        .gnt_any    (w_gnt_any),
        .gnt_idx    (w_gnt_idx),
        .gnt_onehot (w_gnt_oh)
    );

    // Register can take a new word when empty or when it is drained this cycle.
    assign w_load     = ~r_valid | out_ready;
    assign w_fire     = w_load & w_gnt_any;
    assign w_mux_data = in_data[w_gnt_idx];

    // rst_n gating keeps upstream from seeing a handshake that reset will drop.
    assign in_ready   = (rst_n && w_load) ? w_gnt_oh : 4'b0000;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= 2'd0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= 2'd0;
        end else if (w_load) begin
            r_valid <= w_gnt_any;
            if (w_fire) begin
                r_data <= w_mux_data;
                r_sel  <= w_gnt_idx;
                r_ptr  <= w_gnt_idx + 2'd1;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_sel   = r_sel;

endmodule : rr_arb_mux_4
`default_nettype wire

// File: doc/rr_arb_mux_4.md
Name: rr_arb_mux_4

Overview:
- 4-channel round-robin arbiter with a registered output stage, built as the stage directly upstream of the 4:1 data mux.
- Accepts four valid/ready streams and picks one fairly.
- Drives the 2-bit select code plus the selected data word, registered, to the downstream consumer over a valid/ready interface.
- Throughput is one word per cycle; input-to-output latency is 1 cycle.

Parameters:
- WIDTH, 4, width of each data word.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  4  per-channel valid; bit i is channel i.
- in_data  input  4 x WIDTH  per-channel data, unpacked array [0:3].
- in_ready  output  4  per-channel ready; at most one bit is high per cycle.
- out_valid  output  1  output register holds a word.
- out_data  output  WIDTH  registered data of the granted channel.
- out_sel  output  2  registered index of the channel that supplied out_data.
- out_ready  input  1  downstream accepts the word.

Behaviour:
- Reset: one clock, clk; reset rst_n is asynchronous, active-low.
  - Reset values: out_valid=0, out_data=0, out_sel=0, priority pointer ptr=0 (channel 0 highest priority).
  - Deassertion is synchronised by the integrator, not inside this block.
- Reset mid-operation: rst_n low clears out_valid and ptr immediately, regardless of clk.
  - Any word in the output register is dropped.
  - in_ready is 0 while rst_n is low.
- Load enable: load = ~out_valid | out_ready.
  - The output register may be refilled in the same cycle it is drained.
- Grant (combinational):
  - Search in_valid starting at channel ptr, then ptr+1, ptr+2, ptr+3, all mod 4.
  - The first valid channel is g.
  - If no channel is valid, there is no grant.
- in_ready[i] = load & grant_onehot[i].
  - in_ready may depend combinationally on in_valid.
  - in_valid must not depend on in_ready; the upstream side obeys the standard rule.
- Handshake on channel g: in_valid[g] & in_ready[g]. At the next edge:
  - out_data <= in_data[g], out_sel <= g, out_valid <= 1, ptr <= (g+1) mod 4 (2-bit wrap).
- load=1 with no valid input: out_valid <= 0 next edge. out_data and out_sel hold their last values (don't-care while out_valid=0).
- load=0 (out_valid=1, out_ready=0):
  - out_valid, out_data, out_sel and ptr all hold.
  - All in_ready are 0.
- ptr changes only on a successful input handshake, never on idle cycles.
- Fairness: with all four channels continuously valid and out_ready=1, the grant order is 0,1,2,3,0,...
  - Any single continuously-valid channel waits at most 3 accepted words.
- Simultaneous drain and fill: out_ready=1 with a valid request gives back-to-back words with out_valid held high, no bubble.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_sel do not change.
- X on in_data of a non-granted channel never propagates to the outputs.
- X on in_data of the granted channel propagates to out_data.

Decomposition:
- Shared package arb_pkg:
  - localparam N_CH = 4.
  - typedef logic [1:0] ch_idx_t.
  - function rotate_l4 (4-bit rotate used by the picker).
- One sub-module, rr_pick_4 (purely combinational):
  - Inputs: req[3:0], ptr (ch_idx_t).
  - Outputs: gnt_any, gnt_idx (ch_idx_t), gnt_onehot[3:0].
  - Method: rotate req by ptr, fixed-priority pick, un-rotate.
- Top level holds ptr, the output register and the load/ready logic.
- Data selection is a 4:1 mux indexed by gnt_idx.

Test Plan:
- Reset idle: rst_n=0 then 1, no inputs.
  - Required: out_valid=0, out_sel=0, out_data=0, in_ready=0000 while rst_n is low.
  - Required: after release with in_valid=0000, in_ready=0000.
- Single channel: in_valid=0100, in_data[2]='hC, out_ready=1.
  - Required: in_ready=0100; next cycle out_valid=1, out_sel=2, out_data='hC; ptr becomes 3.
- Full contention: in_valid=1111, in_data={'hA,'hB,'hC,'hD} for channels 0..3, out_ready=1 for 8 cycles.
  - Required: out_sel sequence 0,1,2,3,0,1,2,3; out_data a,b,c,d,a,b,c,d; out_valid held 1 with no bubbles.
- Backpressure: out_valid=1 with out_sel=1, data 'hB; hold out_ready=0 for 3 cycles with in_valid=1111.
  - Required: in_ready=0000; out_data='hB and out_sel=1 stable.
  - Release out_ready=1: next word is channel 2 (out_data='hC).
- Pointer wrap and skip: ptr=3, in_valid=0011.
  - Required: grant channel 0 (out_sel=0), then channel 1; channel 3 absent is skipped without changing ptr.
- Async reset mid-stream: during full contention, pull rst_n low between edges.
  - Required: out_valid drops to 0 immediately.
  - Required: after release, the first grant is channel 0.
